// File: rtl/uart_rx_param.sv
// uart_rx_param: UART receiver with one-word valid/ready holding register and per-frame error flags.
// Parity bit reception and checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_Clock,
  input  logic                 rst,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Ready,
  output logic                 o_Valid,
  output logic [DATA_BITS-1:0] o_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic ferr_q, ferr_d, out_ferr_q, out_ferr_d;
  logic valid_q, valid_d, overrun_q, overrun_d;
  logic rx_s, tick, done, load;
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d, out_perr_q, out_perr_d;
`endif
  assign rx_s = sync_q[1];
  assign tick = cnt_q == CNT_LAST;
  assign done = state_q == STOP && tick && idx_q == STOP_LAST;
  assign load = done && (!valid_q || i_Ready);
  always_ff @(posedge i_Clock or negedge rst)
    if (!rst) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      ferr_q     <= 1'b0;
      out_ferr_q <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      out_perr_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], i_Rx_Serial};
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      ferr_q     <= ferr_d;
      out_ferr_q <= out_ferr_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
      out_perr_q <= out_perr_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = rx_s ? IDLE : START;
      START: if (cnt_q == CNT_HALF) state_d = rx_s ? IDLE : DATA;
      DATA:  if (tick && idx_q == DATA_LAST)
`ifdef UART_RX_PARITY_EN
        state_d = PARITY;
      PARITY: if (tick) state_d = STOP;
`else
        state_d = STOP;
`endif
      STOP:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Counter and bit index restart on every state change, so each phase counts from zero.
  always_comb begin
    cnt_d      = (state_q != state_d || state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
    idx_d      = (state_q != state_d || state_q == IDLE) ? '0 : tick ? idx_q + 4'd1 : idx_q;
    shift_d    = (state_q == DATA && tick) ? {rx_s, shift_q[DATA_BITS-1:1]} : shift_q;
    ferr_d     = state_q == START ? 1'b0 : (state_q == STOP && tick && !rx_s) ? 1'b1 : ferr_q;
    data_d     = load ? shift_q : data_q;
    out_ferr_d = load ? (ferr_q | ~rx_s) : out_ferr_q;
    valid_d    = load | (valid_q & ~i_Ready);
    overrun_d  = overrun_q | (done & ~load);
`ifdef UART_RX_PARITY_EN
    perr_d     = (state_q == PARITY && tick) ? ^{shift_q, rx_s, PARITY_ODD[0]} : perr_q;
    out_perr_d = load ? perr_q : out_perr_q;
`endif
  end
  assign o_Valid     = valid_q;
  assign o_Data      = data_q;
  assign o_Frame_Err = out_ferr_q;
  assign o_Overrun   = overrun_q;
  assign o_Busy      = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = out_perr_q;
`else
  assign o_Parity_Err = 1'b0 & PARITY_ODD[0];
`endif
endmodule
